// File: rtl/mips_regfile.sv
// MIPS 32x32 register file: two combinational read ports, one write port, r0 hardwired to zero.
// Latency: reads are zero-cycle (address to data); writes land on the rising clk edge.
// Backpressure: none, every write is accepted. Define REGFILE_BYPASS_EN to forward write_data to same-cycle reads.
module mips_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [4:0]       write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_reg1,
  input  logic [4:0]       read_reg2,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  logic [WIDTH-1:0] regs [DEPTH];

  // A write is only live out of reset, with enable set, to a nonzero address.
  // Gating on the enable first keeps X/Z addresses from reaching the array when idle.
  logic wr_live;
  assign wr_live = reg_write && (write_reg != 5'd0) && !reset;

  // Storage: async clear of every entry; r0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[write_reg] <= write_data;
    end
  end

  // Read port 1: zero under reset and for r0, otherwise stored (or forwarded) value.
  always_comb begin
    read_data1 = '0;
    if (!reset && (read_reg1 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (read_reg1 == write_reg)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs[read_reg1];
      end
`else
      read_data1 = regs[read_reg1];
`endif
    end
  end

  // Read port 2: same decode as port 1, evaluated independently.
  always_comb begin
    read_data2 = '0;
    if (!reset && (read_reg2 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (read_reg2 == write_reg)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs[read_reg2];
      end
`else
      read_data2 = regs[read_reg2];
`endif
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile: reset, write/read, r0, enable, bypass, reset-vs-write.
// Inputs change 1 time unit after the rising edge; outputs are sampled in mid-cycle.
// Expectations for the forwarding case follow the REGFILE_BYPASS_EN build setting.
module tb_mips_regfile;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks;
  int failures;

  mips_regfile #(.WIDTH(32), .DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving a small settle margin.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bypass_exp;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'h0;
    read_reg1  = 5'd5;
    read_reg2  = 5'd31;
    #2;
    check("reset_rd1", read_data1, 32'h0);
    check("reset_rd2", read_data2, 32'h0);

    // Writes during reset are ignored and reads stay zero.
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'h0000_0077;
    tick();
    check("reset_write_ignored", read_data1, 32'h0);
    reg_write  = 1'b0;
    reset      = 1'b0;
    #1;
    check("post_reset_r5", read_data1, 32'h0);

    // Async reset clears a stored value with no clk edge.
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'hDEAD_BEEF;
    tick();
    reg_write  = 1'b0;
    #1;
    check("r5_written", read_data1, 32'hDEAD_BEEF);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_r5", read_data1, 32'h0);
    reset = 1'b0;

    // First write after reset release lands on the next edge.
    tick();
    check("r5_stays_clear", read_data1, 32'h0);
    reg_write  = 1'b1;
    write_reg  = 5'd6;
    write_data = 32'h0000_CAFE;
    read_reg1  = 5'd6;
    tick();
    check("first_write_after_reset", read_data1, 32'h0000_CAFE);

    // Write r7 and r31, then read both ports.
    write_reg  = 5'd7;
    write_data = 32'h1234_5678;
    tick();
    write_reg  = 5'd31;
    write_data = 32'hFFFF_FFFF;
    tick();
    reg_write = 1'b0;
    read_reg1 = 5'd7;
    read_reg2 = 5'd31;
    #1;
    check("rd1_r7", read_data1, 32'h1234_5678);
    check("rd2_r31", read_data2, 32'hFFFF_FFFF);
    read_reg2 = 5'd7;
    #1;
    check("same_addr_rd1", read_data1, 32'h1234_5678);
    check("same_addr_rd2", read_data2, 32'h1234_5678);

    // r0 ignores writes and is never forwarded.
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'hAAAA_5555;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    #1;
    check("r0_no_bypass", read_data1, 32'h0);
    tick();
    check("r0_rd1", read_data1, 32'h0);
    check("r0_rd2", read_data2, 32'h0);

    // Enable off: r3 keeps its value across three edges.
    write_reg  = 5'd3;
    write_data = 32'h0000_0001;
    tick();
    reg_write  = 1'b0;
    write_data = 32'h0000_0002;
    read_reg1  = 5'd3;
    repeat (3) tick();
    check("enable_off_r3", read_data1, 32'h0000_0001);

    // Unknown write address with enable low leaves state alone.
    write_reg = 5'bxxxxx;
    read_reg2 = 5'd7;
    tick();
    check("x_addr_r3", read_data1, 32'h0000_0001);
    check("x_addr_r7", read_data2, 32'h1234_5678);

    // Write to one address while reading others.
    reg_write  = 1'b1;
    write_reg  = 5'd8;
    write_data = 32'h0000_0088;
    read_reg1  = 5'd31;
    read_reg2  = 5'd7;
    tick();
    check("indep_rd1", read_data1, 32'hFFFF_FFFF);
    check("indep_rd2", read_data2, 32'h1234_5678);
    read_reg1 = 5'd8;
    #1;
    check("r8_written", read_data1, 32'h0000_0088);

    // Same-cycle read of the address being written.
    write_reg  = 5'd9;
    write_data = 32'h0000_0011;
    tick();
    write_data = 32'h0000_0022;
    read_reg1  = 5'd9;
    read_reg2  = 5'd7;
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 32'h0000_0022;
`else
    bypass_exp = 32'h0000_0011;
`endif
    #1;
    check("bypass_before_edge", read_data1, bypass_exp);
    check("bypass_other_port", read_data2, 32'h1234_5678);
    tick();
    reg_write = 1'b0;
    #1;
    check("bypass_after_edge", read_data1, 32'h0000_0022);

    // Reset rising on the same edge as a write: reset wins.
    reg_write  = 1'b1;
    write_reg  = 5'd4;
    write_data = 32'h0000_0005;
    read_reg1  = 5'd4;
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("reset_vs_write_during", read_data1, 32'h0);
    #3;
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    check("reset_vs_write_r4", read_data1, 32'h0);
    check("reset_cleared_r7", read_data2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_regfile.md
MIPS_REGFILE -- requirements
Module: mips_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the register count; the address width SHALL be 5 bits (log2 of DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all writes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port reg_write, input, 1, the write enable.
REQ-006 The block SHALL have port write_reg, input, 5, the write address.
REQ-007 The block SHALL have port write_data, input, WIDTH, the write value.
REQ-008 The block SHALL have port read_reg1, input, 5, the read port 1 address.
REQ-009 The block SHALL have port read_reg2, input, 5, the read port 2 address.
REQ-010 The block SHALL have port read_data1, output, WIDTH, the read port 1 data, which feeds the ALU operand path.
REQ-011 The block SHALL have port read_data2, output, WIDTH, the read port 2 data, which feeds the ALUSrc 32-bit 2:1 select stage as input1.

Function
REQ-012 The block SHALL store DEPTH registers of WIDTH bits each, addressed 0..31.
REQ-013 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-014 On a clk rising edge with reg_write=1 and write_reg!=0, registers[write_reg] SHALL take the value write_data.
REQ-015 When reg_write=0, no register SHALL change.
REQ-016 Register 0 SHALL read 0 at all times; writes to address 0 SHALL be discarded, even when reg_write=1.
REQ-017 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-018 A write and reads in the same cycle to different addresses SHALL NOT interact.
REQ-019 A same-cycle read of the address being written SHALL follow REQ-028 or REQ-029.
REQ-020 An X or Z value on an address with the enable deasserted SHALL NOT corrupt stored state.

Reset
REQ-021 Asserting reset SHALL clear all registers to 0 immediately, without waiting for a clk edge.
REQ-022 While reset=1, read_data1 and read_data2 SHALL be 0 for every address, and writes SHALL be ignored.
REQ-023 When reset asserts on the same clk edge as a write, reset SHALL win and the register SHALL be 0.
REQ-024 After reset deasserts, the first write SHALL take effect on the next clk rising edge.

Configuration
REQ-025 The macro REGFILE_BYPASS_EN SHALL select the write-to-read bypass behaviour.
REQ-026 The bypass applies when reg_write=1, write_reg!=0, reset=0, and the read address equals write_reg.
REQ-027 The bypass is determined on each read port independently.
REQ-028 With REGFILE_BYPASS_EN defined, a read meeting REQ-026 SHALL return write_data combinationally in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN, a read meeting REQ-026 SHALL return the old stored value until the clk edge, and the new value after it.
REQ-030 Address 0 SHALL never be bypassed in either build.

Verification
REQ-031 Reset: write 0xDEADBEEF to r5, then pulse reset mid-cycle with no clk edge -> read_reg1=5 gives 0 immediately.
REQ-032 Write/read: write r7=0x12345678 and r31=0xFFFFFFFF -> after the edges, read_reg1=7 and read_reg2=31 give 0x12345678 and 0xFFFFFFFF.
REQ-033 Zero register: reg_write=1, write_reg=0, write_data=0xAAAA5555 -> read r0 on both ports gives 0.
REQ-034 Enable off: write r3=0x1, then set reg_write=0 with write_data=0x2 for 3 edges -> r3 still reads 0x1.
REQ-035 Bypass: r9 holds 0x11, then write r9=0x22 with read_reg1=9 before the edge.
- Bypass build -> read_data1 gives 0x22 before the edge.
- Non-bypass build -> read_data1 gives 0x11 before the edge and 0x22 after it.
REQ-036 Reset versus write: reset rises on the same edge as a write of r4=0x5 -> r4 reads 0.
